// File: rtl/min_occupied_strip_finder_pkg.sv
// Shared constants for the minimum-occupied-strip finder: table geometry,
// field widths, FSM state encoding and the "nothing fits" selector code.
package min_occupied_strip_finder_pkg;

  localparam int NUM_STRIPS  = 13;
  localparam int STRIP_WIDTH = 128;
  localparam int ID_W        = 4;
  localparam int WID_W       = 8;

  // Sized copies so comparisons stay width-clean.
  localparam logic [ID_W-1:0] NUM_STRIPS_ID  = ID_W'(NUM_STRIPS);
  localparam logic [WID_W:0]  STRIP_WIDTH_X  = (WID_W+1)'(STRIP_WIDTH);
  localparam logic [WID_W-1:0] STRIP_WIDTH_W = WID_W'(STRIP_WIDTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD1  = 3'd1;
  localparam logic [2:0] ST_RD2  = 3'd2;
  localparam logic [2:0] ST_RD3  = 3'd3;
  localparam logic [2:0] ST_CMP  = 3'd4;

  localparam logic [1:0] NO_FIT = 2'd0;

endpackage

// File: rtl/min_occupied_strip_finder_table.sv
// Per-strip occupancy register file: saturating commit port, one-cycle error
// pulse, and a combinational read port that forwards a same-cycle commit.
module strip_occupancy_table
  import min_occupied_strip_finder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic [ID_W-1:0]  commit_id,
  input  logic [WID_W-1:0] commit_width,
  output logic             commit_err,
  input  logic [ID_W-1:0]  rd_id,
  output logic [WID_W-1:0] rd_data
);

  logic [WID_W-1:0] table_q [NUM_STRIPS];
  logic             commit_err_q;
  logic             id_ok;
  logic             sat;
  logic [WID_W:0]   sum;
  logic [WID_W-1:0] commit_val;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_ok      = commit_id < NUM_STRIPS_ID;
    sum        = '0;
    if (id_ok) sum = {1'b0, table_q[commit_id]} + {1'b0, commit_width};
    sat        = id_ok && (sum > STRIP_WIDTH_X);
    commit_val = sat ? STRIP_WIDTH_W : sum[WID_W-1:0];
  end

  // A commit landing in the same cycle as the read is forwarded, so the
  // reader sees the post-commit occupancy.
  always_comb begin
    rd_data = '0;
    if (rd_id < NUM_STRIPS_ID) begin
      rd_data = table_q[rd_id];
      if (commit_valid && (commit_id == rd_id)) rd_data = commit_val;
    end
  end

  // NOTE: the table is architecturally cleared by reset (a fresh placement
  // area is empty), so this memory is reset on purpose, entry by entry.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STRIPS; i++) table_q[i] <= '0;
      commit_err_q <= 1'b0;
    end else begin
      commit_err_q <= commit_valid & (~id_ok | sat);
      if (commit_valid && id_ok) table_q[commit_id] <= commit_val;
    end
  end

  assign commit_err = commit_err_q;

endmodule

// File: rtl/min_occupied_strip_finder.sv
// Query FSM: snapshots up to three candidate strips over RD1..RD3, then picks
// the least occupied candidate that still fits the program in CMP.
module min_occupied_strip_finder
  import min_occupied_strip_finder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             query_valid,
  output logic             query_ready,
  input  logic [ID_W-1:0]  cand_id_1,
  input  logic [ID_W-1:0]  cand_id_2,
  input  logic [ID_W-1:0]  cand_id_3,
  input  logic [2:0]       cand_en,
  input  logic [WID_W-1:0] prog_width,
  input  logic             commit_valid,
  input  logic [ID_W-1:0]  commit_id,
  input  logic [WID_W-1:0] commit_width,
  output logic             commit_err,
  output logic [ID_W-1:0]  strip_id_1,
  output logic [ID_W-1:0]  strip_id_2,
  output logic [ID_W-1:0]  strip_id_3,
  output logic [WID_W-1:0] occupied_width_1,
  output logic [WID_W-1:0] occupied_width_2,
  output logic [WID_W-1:0] occupied_width_3,
  output logic [1:0]       min_occupied_width_no,
  output logic             result_valid
);

  logic [2:0]             state_q, state_d;
  logic [2:0][ID_W-1:0]   cid_q;
  logic [2:0]             en_q;
  logic [WID_W-1:0]       pw_q;
  logic [2:0][WID_W-1:0]  occ_q;
  logic [2:0][ID_W-1:0]   sid_q;
  logic [2:0][WID_W-1:0]  ow_q;
  logic [1:0]             no_q;
  logic                   rv_q;

  logic                   accept;
  logic [1:0]             rd_sel;
  logic [ID_W-1:0]        rd_id;
  logic [WID_W-1:0]       rd_data;
  logic [2:0]             fits;
  logic [1:0]             win_no;
  logic [WID_W-1:0]       win_occ;

  assign query_ready = (state_q == ST_IDLE);
  assign accept      = query_valid & query_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (query_valid) state_d = ST_RD1;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_RD3;
      ST_RD3:  state_d = ST_CMP;
      ST_CMP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_sel = 2'd0;
    rd_id  = cid_q[0];
    unique case (state_q)
      ST_RD2:  begin rd_sel = 2'd1; rd_id = cid_q[1]; end
      ST_RD3:  begin rd_sel = 2'd2; rd_id = cid_q[2]; end
      default: ;
    endcase
  end

  strip_occupancy_table u_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_width (commit_width),
    .commit_err   (commit_err),
    .rd_id        (rd_id),
    .rd_data      (rd_data)
  );

  // Strict less-than keeps the lowest-index candidate on ties.
  always_comb begin
    fits    = '0;
    win_no  = NO_FIT;
    win_occ = '0;
    for (int i = 0; i < 3; i++) begin
      fits[i] = en_q[i] && (({1'b0, occ_q[i]} + {1'b0, pw_q}) <= STRIP_WIDTH_X);
      if (fits[i] && ((win_no == NO_FIT) || (occ_q[i] < win_occ))) begin
        win_no  = 2'(i + 1);
        win_occ = occ_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cid_q   <= '0;
      en_q    <= '0;
      pw_q    <= '0;
      occ_q   <= '0;
      sid_q   <= '0;
      ow_q    <= '0;
      no_q    <= NO_FIT;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= (state_q == ST_CMP);
      if (accept) begin
        cid_q <= {cand_id_3, cand_id_2, cand_id_1};
        en_q  <= cand_en & {cand_id_3 < NUM_STRIPS_ID,
                            cand_id_2 < NUM_STRIPS_ID,
                            cand_id_1 < NUM_STRIPS_ID};
        pw_q  <= prog_width;
      end
      if ((state_q == ST_RD1) || (state_q == ST_RD2) || (state_q == ST_RD3))
        occ_q[rd_sel] <= en_q[rd_sel] ? rd_data : '0;
      if (state_q == ST_CMP) begin
        sid_q <= cid_q;
        ow_q  <= occ_q;
        no_q  <= win_no;
      end
    end
  end

  assign strip_id_1            = sid_q[0];
  assign strip_id_2            = sid_q[1];
  assign strip_id_3            = sid_q[2];
  assign occupied_width_1      = ow_q[0];
  assign occupied_width_2      = ow_q[1];
  assign occupied_width_3      = ow_q[2];
  assign min_occupied_width_no = no_q;
  assign result_valid          = rv_q;

endmodule

// File: tb/tb_min_occupied_strip_finder.sv
// Table-driven bench for min_occupied_strip_finder: commit/query vectors with
// a result scoreboard, plus a hand-written mid-query reset sequence.
module tb_min_occupied_strip_finder;

  logic       clk;
  logic       rst_n;
  logic       query_valid;
  logic       query_ready;
  logic [3:0] cand_id_1, cand_id_2, cand_id_3;
  logic [2:0] cand_en;
  logic [7:0] prog_width;
  logic       commit_valid;
  logic [3:0] commit_id;
  logic [7:0] commit_width;
  logic       commit_err;
  logic [3:0] strip_id_1, strip_id_2, strip_id_3;
  logic [7:0] occupied_width_1, occupied_width_2, occupied_width_3;
  logic [1:0] min_occupied_width_no;
  logic       result_valid;

  min_occupied_strip_finder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .query_valid           (query_valid),
    .query_ready           (query_ready),
    .cand_id_1             (cand_id_1),
    .cand_id_2             (cand_id_2),
    .cand_id_3             (cand_id_3),
    .cand_en               (cand_en),
    .prog_width            (prog_width),
    .commit_valid          (commit_valid),
    .commit_id             (commit_id),
    .commit_width          (commit_width),
    .commit_err            (commit_err),
    .strip_id_1            (strip_id_1),
    .strip_id_2            (strip_id_2),
    .strip_id_3            (strip_id_3),
    .occupied_width_1      (occupied_width_1),
    .occupied_width_2      (occupied_width_2),
    .occupied_width_3      (occupied_width_3),
    .min_occupied_width_no (min_occupied_width_no),
    .result_valid          (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_query;
    logic [3:0] c_id;
    logic [7:0] c_w;
    logic       c_err;
    logic [3:0] id1, id2, id3;
    logic [2:0] en;
    logic [7:0] pw;
    int         inj_k;
    logic [3:0] inj_id;
    logic [7:0] inj_w;
    logic [7:0] w1, w2, w3;
    logic [1:0] no;
  } vec_t;

  typedef struct {
    logic [2:0][3:0] ids;
    logic [2:0][7:0] ws;
    logic [1:0]      no;
    int              cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mkc(logic [3:0] id, logic [7:0] w, logic err);
    vec_t v;
    v = '{default: '0};
    v.is_query = 1'b0; v.c_id = id; v.c_w = w; v.c_err = err; v.inj_k = -1;
    return v;
  endfunction

  function automatic vec_t mkq(logic [3:0] i1, logic [3:0] i2, logic [3:0] i3,
                               logic [2:0] en, logic [7:0] pw,
                               int k, logic [3:0] kid, logic [7:0] kw,
                               logic [7:0] w1, logic [7:0] w2, logic [7:0] w3,
                               logic [1:0] no);
    vec_t v;
    v = '{default: '0};
    v.is_query = 1'b1; v.id1 = i1; v.id2 = i2; v.id3 = i3; v.en = en; v.pw = pw;
    v.inj_k = k; v.inj_id = kid; v.inj_w = kw;
    v.w1 = w1; v.w2 = w2; v.w3 = w3; v.no = no;
    return v;
  endfunction

  // Scoreboard: each result_valid pops one expectation, checked on the falling edge.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious result_valid", 32'(result_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result cycle",     32'(cyc),                   32'(e.cyc));
        check("strip_id_1",       32'(strip_id_1),            32'(e.ids[0]));
        check("strip_id_2",       32'(strip_id_2),            32'(e.ids[1]));
        check("strip_id_3",       32'(strip_id_3),            32'(e.ids[2]));
        check("occupied_width_1", 32'(occupied_width_1),      32'(e.ws[0]));
        check("occupied_width_2", 32'(occupied_width_2),      32'(e.ws[1]));
        check("occupied_width_3", 32'(occupied_width_3),      32'(e.ws[2]));
        check("min_no",           32'(min_occupied_width_no), 32'(e.no));
      end
    end
  end

  task automatic run_commit(input vec_t v);
    @(negedge clk);
    commit_valid = 1'b1; commit_id = v.c_id; commit_width = v.c_w;
    @(negedge clk);
    commit_valid = 1'b0;
    check("commit_err pulse", 32'(commit_err), 32'(v.c_err));
    @(negedge clk);
    check("commit_err clears", 32'(commit_err), 32'd0);
  endtask

  task automatic run_query(input vec_t v);
    exp_t e;
    @(negedge clk);
    check("query_ready idle", 32'(query_ready), 32'd1);
    query_valid = 1'b1;
    cand_id_1 = v.id1; cand_id_2 = v.id2; cand_id_3 = v.id3;
    cand_en = v.en; prog_width = v.pw;
    @(negedge clk);
    e.ids = {v.id3, v.id2, v.id1};
    e.ws  = {v.w3, v.w2, v.w1};
    e.no  = v.no;
    e.cyc = cyc + 4;
    sb_q.push_back(e);
    // Keep a different request on the bus while busy; it must be ignored.
    cand_id_1 = 4'd12; cand_id_2 = 4'd12; cand_id_3 = 4'd12;
    cand_en = 3'b111; prog_width = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) query_valid = 1'b0;
      if (k == 1) check("query_ready busy", 32'(query_ready), 32'd0);
      if (k == v.inj_k) begin
        commit_valid = 1'b1; commit_id = v.inj_id; commit_width = v.inj_w;
      end
      @(negedge clk);
      commit_valid = 1'b0;
    end
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("result timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; query_valid = 1'b0;
    cand_id_1 = '0; cand_id_2 = '0; cand_id_3 = '0; cand_en = '0; prog_width = '0;
    commit_valid = 1'b0; commit_id = '0; commit_width = '0;

    //            ids        en      pw  inj        w1   w2   w3   no
    vecs.push_back(mkq(2, 5, 7, 3'b111, 10, -1, 0, 0,   0,   0,   0, 1));
    vecs.push_back(mkc(2, 100, 0));
    vecs.push_back(mkc(5,  40, 0));
    vecs.push_back(mkc(7,  60, 0));
    vecs.push_back(mkq(2, 5, 7, 3'b111, 30, -1, 0, 0, 100,  40,  60, 2));
    vecs.push_back(mkc(5,  90, 1));
    vecs.push_back(mkq(5, 5, 5, 3'b111,  1, -1, 0, 0, 128, 128, 128, 0));
    vecs.push_back(mkq(5, 5, 5, 3'b111,  0, -1, 0, 0, 128, 128, 128, 1));
    vecs.push_back(mkq(2, 5, 7, 3'b111, 28, -1, 0, 0, 100, 128,  60, 3));
    vecs.push_back(mkq(7, 7, 7, 3'b111, 10,  2, 7, 10, 60,  60,  70, 1));
    vecs.push_back(mkq(7, 7, 7, 3'b111, 10,  3, 7, 10, 70,  70,  70, 1));
    vecs.push_back(mkq(7, 7, 7, 3'b111, 49, -1, 0, 0,  80,  80,  80, 0));
    vecs.push_back(mkq(7, 2, 7, 3'b111, 48, -1, 0, 0,  80, 100,  80, 1));
    vecs.push_back(mkq(15, 2, 7, 3'b010, 10, -1, 0, 0,  0, 100,   0, 2));
    vecs.push_back(mkq(13, 7, 2, 3'b111, 10, -1, 0, 0,  0,  80, 100, 2));
    vecs.push_back(mkc(14, 5, 1));
    vecs.push_back(mkc(13, 5, 1));
    vecs.push_back(mkq(2, 5, 7, 3'b111, 10, -1, 0, 0, 100, 128,  80, 3));
    vecs.push_back(mkc(0, 128, 0));
    vecs.push_back(mkq(0, 1, 0, 3'b111,  0, -1, 0, 0, 128,   0, 128, 2));
    vecs.push_back(mkq(1, 0, 1, 3'b101,  0, -1, 0, 0,   0,   0,   0, 1));
    vecs.push_back(mkq(9, 5, 9, 3'b010,  0, -1, 0, 0,   0, 128,   0, 2));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset query_ready",  32'(query_ready),           32'd1);
    check("reset result_valid", 32'(result_valid),          32'd0);
    check("reset commit_err",   32'(commit_err),            32'd0);
    check("reset min_no",       32'(min_occupied_width_no), 32'd0);
    check("reset occ_w_1",      32'(occupied_width_1),      32'd0);
    check("reset strip_id_3",   32'(strip_id_3),            32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].is_query) run_query(vecs[i]);
      else                  run_commit(vecs[i]);
    end

    // Reset during RD2: the in-flight query must vanish without a result.
    @(negedge clk);
    query_valid = 1'b1;
    cand_id_1 = 4'd2; cand_id_2 = 4'd5; cand_id_3 = 4'd7; cand_en = 3'b111; prog_width = 8'd10;
    @(negedge clk);
    query_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst result_valid", 32'(result_valid),          32'd0);
    check("midrst strip_id_1",   32'(strip_id_1),            32'd0);
    check("midrst occ_w_2",      32'(occupied_width_2),      32'd0);
    check("midrst min_no",       32'(min_occupied_width_no), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post-rst query_ready", 32'(query_ready), 32'd1);
    run_query(mkq(2, 5, 7, 3'b111,   0, -1, 0, 0, 0, 0, 0, 1));
    run_query(mkq(0, 7, 12, 3'b111, 128, -1, 0, 0, 0, 0, 0, 1));

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
